// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
// The design is sized here so that the controller, the arbiter and any
// wrapper around the 8x8 RAM all agree on widths.
package ram_fifo_pkg;

    localparam int DW    = 8;        // data width, must match the RAM
    localparam int AW    = 3;        // address width
    localparam int DEPTH = 2 ** AW;  // FIFO entries

    // Which side wins the next contended cycle.
    localparam logic PRIO_POP  = 1'b0;
    localparam logic PRIO_PUSH = 1'b1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

    // Pointer advance; wraps 7 -> 0 naturally through the AW-bit width.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/ram_fifo_arb.sv
// Two-requester round-robin arbiter between push and pop.
// The RAM performs one access per clock, so when both sides can proceed
// only one is granted; the priority flips after every contended cycle.
module ram_fifo_arb
    import ram_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_push,
    input  logic req_pop,
    output logic gnt_push,
    output logic gnt_pop
);

    logic prio_q;
    logic prio_d;
    logic contended;

    // Grant logic and next priority; an uncontended request always wins.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        prio_d    = prio_q;
        contended = !rst && req_push && req_pop;
        gnt_push  = !rst && req_push && (!req_pop || (prio_q == PRIO_PUSH));
        gnt_pop   = !rst && req_pop  && (!req_push || (prio_q == PRIO_POP));
        if (contended) begin
            prio_d = ~prio_q;
        end
    end

    // Priority flop; pop is favoured first after reset.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (rst) begin
            prio_q <= PRIO_POP;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an 8x8 single-port synchronous RAM.
// Holds write/read pointers, occupancy and the read-valid flag, and drives
// the RAM port combinationally so the RAM samples at the same edge that
// advances the pointers. Read data comes straight from the RAM's register.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_CS,
    output logic          ram_WE,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_dataIn,
    input  logic [DW-1:0] ram_dataOut
);

    // NOTE: the RAM contents are never cleared; resetting the pointers and count is enough to make the FIFO empty.
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic rd_valid_q, rd_valid_d;

    logic req_push, req_pop;
    logic gnt_push, gnt_pop;
    logic push_acc, pop_acc;

    ram_fifo_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_push (req_push),
        .req_pop  (req_pop),
        .gnt_push (gnt_push),
        .gnt_pop  (gnt_pop)
    );

    // Status, handshakes and RAM port drive from the current requests.
    always_comb begin
        full     = (count_q == cnt_t'(DEPTH));
        empty    = (count_q == '0);
        req_push = push && !full;
        req_pop  = pop && !empty;

        // A side is ready unless it is blocked by reset, by its boundary,
        // or by losing a contended cycle to the other side.
        push_ready = !rst && !full  && !(gnt_pop  && req_push);
        pop_ready  = !rst && !empty && !(gnt_push && req_pop);
        push_acc   = push && push_ready;
        pop_acc    = pop && pop_ready;

        ram_CS     = push_acc || pop_acc;
        ram_WE     = push_acc;
        ram_addr   = push_acc ? wr_ptr_q : rd_ptr_q;
        ram_dataIn = push_data;
    end

    // Next-state for pointers, occupancy and read-valid.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = pop_acc;
        if (push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + cnt_t'(1);
        end else if (pop_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d  = count_q - cnt_t'(1);
        end
    end

    // State registers; a reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Registered outputs and RAM read-data pass-through.
    always_comb begin
        count    = count_q;
        rd_valid = rd_valid_q;
        rd_data  = ram_dataOut;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl wired to a behavioural 8x8 synchronous RAM.
// A queue-based reference model predicts handshakes and status each cycle;
// accepted pops push expected read data into a scoreboard that a separate
// monitor drains whenever the DUT raises rd_valid.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic          push_ready, pop_ready, rd_valid, full, empty;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          ram_CS, ram_WE;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop         (pop),
        .pop_ready   (pop_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ram_CS      (ram_CS),
        .ram_WE      (ram_WE),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut)
    );

    // Single-port synchronous RAM: registered read, X when not selected.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_CS) begin
            if (ram_WE) mem[ram_addr] <= ram_dataIn;
            else        ram_dataOut   <= mem[ram_addr];
        end else begin
            ram_dataOut <= 'x;
        end
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW-1:0] m_fifo [$];
    exp_t          sb [$];
    bit            m_prio_push = 1'b0;
    int            m_wr = 0;
    int            m_rd = 0;
    exp_t          mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; status is checked against the model mid-cycle.
    task automatic cycle(input bit r, input bit p, input logic [DW-1:0] d, input bit q);
        bit cp, cq, ep, eq, contend, pa, qa;
        @(posedge clk);
        #1;
        rst = r; push = p; push_data = d; pop = q;
        @(negedge clk);
        cp      = !r && (m_fifo.size() < DEPTH);
        cq      = !r && (m_fifo.size() > 0);
        contend = p && q && cp && cq;
        if (contend) begin
            ep = m_prio_push;
            eq = !m_prio_push;
        end else begin
            ep = cp;
            eq = cq;
        end
        pa = p && ep;
        qa = q && eq;
        check("push_ready", 32'(push_ready), 32'(ep));
        check("pop_ready",  32'(pop_ready),  32'(eq));
        check("count",      32'(count),      32'(m_fifo.size()));
        check("full",       32'(full),       32'(m_fifo.size() == DEPTH));
        check("empty",      32'(empty),      32'(m_fifo.size() == 0));
        check("ram_CS",     32'(ram_CS),     32'(pa || qa));
        if (pa || qa) begin
            check("ram_WE",   32'(ram_WE),   32'(pa));
            check("ram_addr", 32'(ram_addr), pa ? 32'(m_wr % DEPTH) : 32'(m_rd % DEPTH));
        end
        if (pa) check("ram_dataIn", 32'(ram_dataIn), 32'(d));
        if (r) begin
            m_fifo.delete();
            m_wr = 0;
            m_rd = 0;
            m_prio_push = 1'b0;
        end else begin
            if (pa) begin
                m_fifo.push_back(d);
                m_wr++;
            end
            if (qa) begin
                sb.push_back('{due: cyc + 1, data: m_fifo.pop_front()});
                m_rd++;
            end
            if (contend) m_prio_push = !m_prio_push;
        end
    endtask

    // Monitor: every rd_valid must match the oldest expected read, on time.
    always @(posedge clk) begin
        #2;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_valid_cycle", 32'(cyc), 32'(mon_e.due));
                check("rd_data", 32'(rd_data), 32'(mon_e.data));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("rd_valid_missing", 32'(rd_valid), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        cycle(1, 0, 8'd0, 0);
        cycle(1, 0, 8'd0, 0);
        cycle(0, 0, 8'd0, 0);

        // Fill with 30..37, then a push on full
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(30 + i), 0);
        cycle(0, 1, 8'd99, 0);

        // Drain from full
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 0);

        // Pop while empty
        cycle(0, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 1);

        // Contended push+pop with two entries preloaded
        cycle(0, 1, 8'd1, 0);
        cycle(0, 1, 8'd2, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'(10 + i), 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'd0, 1);

        // Pointer wrap
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'(20 + i), 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 8'd0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(40 + i), 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 0);

        // Reset during a pop, then a fresh push/pop from address 0
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'(60 + i), 0);
        cycle(1, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 0);
        cycle(0, 1, 8'd50, 0);
        cycle(0, 0, 8'd0, 1);
        cycle(0, 0, 8'd0, 0);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
                  8'($urandom), $urandom_range(0, 9) < 5);
        end

        // Drain and settle
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 8'd0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'd0, 0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
